imem_ctrl: RTL

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load/fetch controller.
package imem_pkg;

    localparam int DEPTH_DEF  = 4096;
    localparam int ADDR_W_DEF = 12;

    // addi x0, x0, 0: returned in place of a faulting fetch
    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RUN   = 2'd3
    } imem_ctrl_state_t;

endpackage

// File: rtl/imem_ctrl.sv
// Instruction memory controller: assembles a little-endian byte stream into
// words written to an external single-port memory, then serves core fetches
// from the same port with one-cycle latency.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_start_i,
    input  logic [ADDR_W:0]   load_len_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    input  logic              fetch_req_i,
    input  logic [31:0]       pc_i,
    output logic              fetch_gnt_o,
    output logic              fetch_valid_o,
    output logic [31:0]       instruction_o,
    output logic              fetch_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              core_stall_o
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

    imem_ctrl_state_t  state_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   wcnt_q;
    logic [1:0]        idx_q;
    logic [31:0]       word_q;
    logic              vld_q;
    logic              err_q;

    logic              run;
    logic              pc_bad;
    logic              hs;

    // State-derived strobes; reset forces the safe values combinationally
    // so the core is held even before the first reset edge lands.
    always_comb begin
        run          = rst_ni && (state_q == ST_RUN);
        byte_ready_o = rst_ni && (state_q == ST_LOAD);
        mem_we_o     = rst_ni && (state_q == ST_WRITE);
        core_stall_o = !run;
        // a load request wins the port over a same-cycle fetch
        fetch_gnt_o  = run && fetch_req_i && !load_start_i;
        hs           = byte_valid_i && byte_ready_o;
        pc_bad       = (|pc_i[1:0]) || (|pc_i[31:ADDR_W+2]);
    end

    // Memory port mux: write address, fetch address, or parked at zero.
    always_comb begin
        mem_wdata_o = word_q;
        if (mem_we_o)
            mem_addr_o = wcnt_q[ADDR_W-1:0];
        else if (fetch_gnt_o)
            mem_addr_o = pc_i[ADDR_W+1:2];
        else
            mem_addr_o = '0;
    end

    // Fetch response: read data arrives straight from the memory in the
    // cycle after the grant; faulting fetches return a NOP instead.
    always_comb begin
        fetch_valid_o = vld_q;
        fetch_err_o   = err_q;
        if (!vld_q)
            instruction_o = '0;
        else if (err_q)
            instruction_o = NOP_INSN;
        else
            instruction_o = mem_rdata_i;
    end

    // Load FSM, byte assembly, word counter and fetch response registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            vld_q <= fetch_gnt_o;
            err_q <= fetch_gnt_o && pc_bad;
            unique case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (load_start_i) begin
                        if (load_len_i != '0) begin
                            state_q <= ST_LOAD;
                            len_q   <= (load_len_i > DEPTH_W) ? DEPTH_W : load_len_i;
                            wcnt_q  <= '0;
                            idx_q   <= '0;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        word_q[8*idx_q +: 8] <= byte_i;
                        idx_q                <= idx_q + 2'd1;
                        if (idx_q == 2'd3)
                            state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    wcnt_q <= wcnt_q + ONE_W;
                    if (wcnt_q + ONE_W == len_q)
                        state_q <= ST_RUN;
                    else
                        state_q <= ST_LOAD;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
